// File: rtl/ei_tdp_ram_req_ctrl.sv
// Request front-end for a true dual-port RAM.
// Two valid/ready request channels (A, B) are registered onto the RAM's two
// port interfaces. Same-address hazards where at least one side writes are
// serialised with a rotating priority token. Read data comes back with a
// response-valid strobe two edges after acceptance.
module ei_tdp_ram_req_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  // channel A
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_wr,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  // channel B
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_wr,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  // RAM port A
  output logic                  ram_we_a,
  output logic                  ram_re_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  // RAM port B
  output logic                  ram_we_b,
  output logic                  ram_re_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  // statistics
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam logic [0:0] TOK_A = 1'b0;
  localparam logic [0:0] TOK_B = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment for the conflict counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [0:0]            tok_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  hazard_p0;
  logic                  acc_a_p0;
  logic                  acc_b_p0;

  logic                  we_a_p1;
  logic                  re_a_p1;
  logic [ADDR_WIDTH-1:0] addr_a_p1;
  logic [DATA_WIDTH-1:0] data_a_p1;
  logic                  we_b_p1;
  logic                  re_b_p1;
  logic [ADDR_WIDTH-1:0] addr_b_p1;
  logic [DATA_WIDTH-1:0] data_b_p1;

  logic                  vld_a_p2;
  logic                  vld_b_p2;

  // ---- p0: acceptance and hazard arbitration (combinational) ----
  // Read/read to the same word is harmless; only a write on either side
  // forces serialisation.
  assign hazard_p0   = a_req_valid & b_req_valid & (a_req_addr == b_req_addr)
                     & (a_req_wr | b_req_wr);
  assign a_req_ready = resetn & (~hazard_p0 | (tok_q == TOK_A));
  assign b_req_ready = resetn & (~hazard_p0 | (tok_q == TOK_B));
  assign acc_a_p0    = a_req_valid & a_req_ready;
  assign acc_b_p0    = b_req_valid & b_req_ready;

  // Hand the token to the loser on every hazard edge and count the stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tok_q <= TOK_A;
      cnt_q <= '0;
    end else if (hazard_p0) begin
      tok_q <= ~tok_q;
      cnt_q <= sat_inc(cnt_q);
    end
  end

  // ---- p1: issue registers driving the RAM ports ----
  // Port A issue: enables last one cycle per accepted request, address/data hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_a_p1   <= 1'b0;
      re_a_p1   <= 1'b0;
      addr_a_p1 <= '0;
      data_a_p1 <= '0;
    end else begin
      we_a_p1 <= acc_a_p0 & a_req_wr;
      re_a_p1 <= acc_a_p0 & ~a_req_wr;
      if (acc_a_p0) begin
        addr_a_p1 <= a_req_addr;
        data_a_p1 <= a_req_wdata;
      end
    end
  end

  // Port B issue: enables last one cycle per accepted request, address/data hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_b_p1   <= 1'b0;
      re_b_p1   <= 1'b0;
      addr_b_p1 <= '0;
      data_b_p1 <= '0;
    end else begin
      we_b_p1 <= acc_b_p0 & b_req_wr;
      re_b_p1 <= acc_b_p0 & ~b_req_wr;
      if (acc_b_p0) begin
        addr_b_p1 <= b_req_addr;
        data_b_p1 <= b_req_wdata;
      end
    end
  end

  // ---- p2: response strobes, aligned with the RAM's registered read data ----
  // Track the read enables one edge later, matching when ram_q becomes valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_a_p2 <= 1'b0;
      vld_b_p2 <= 1'b0;
    end else begin
      vld_a_p2 <= re_a_p1;
      vld_b_p2 <= re_b_p1;
    end
  end

  assign ram_we_a     = we_a_p1;
  assign ram_re_a     = re_a_p1;
  assign ram_addr_a   = addr_a_p1;
  assign ram_data_a   = data_a_p1;
  assign ram_we_b     = we_b_p1;
  assign ram_re_b     = re_b_p1;
  assign ram_addr_b   = addr_b_p1;
  assign ram_data_b   = data_b_p1;

  assign a_rsp_valid  = vld_a_p2;
  assign a_rsp_data   = ram_q_a;
  assign b_rsp_valid  = vld_b_p2;
  assign b_rsp_data   = ram_q_b;

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ei_tdp_ram_req_ctrl.sv
// Directed bench for ei_tdp_ram_req_ctrl with a behavioural dual-port RAM
// and per-channel response scoreboards.
module tb_ei_tdp_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        a_req_valid = 1'b0, a_req_wr = 1'b0;
  logic [9:0]  a_req_addr = '0;
  logic [7:0]  a_req_wdata = '0;
  logic        b_req_valid = 1'b0, b_req_wr = 1'b0;
  logic [9:0]  b_req_addr = '0;
  logic [7:0]  b_req_wdata = '0;
  logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [7:0]  a_rsp_data, b_rsp_data;
  logic        ram_we_a, ram_re_a, ram_we_b, ram_re_b;
  logic [9:0]  ram_addr_a, ram_addr_b;
  logic [7:0]  ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic [15:0] conflict_cnt;

  ei_tdp_ram_req_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .ram_we_a(ram_we_a), .ram_re_a(ram_re_a), .ram_addr_a(ram_addr_a),
    .ram_data_a(ram_data_a), .ram_q_a(ram_q_a),
    .ram_we_b(ram_we_b), .ram_re_b(ram_re_b), .ram_addr_b(ram_addr_b),
    .ram_data_b(ram_data_b), .ram_q_b(ram_q_b),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM: registered read, cleared by reset.
  logic [7:0] mem [0:1023];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      ram_q_a <= 8'h00;
      ram_q_b <= 8'h00;
    end else begin
      if (ram_re_a) ram_q_a <= mem[ram_addr_a];
      if (ram_re_b) ram_q_b <= mem[ram_addr_b];
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int c; } ent_t;
  ent_t qa[$];
  ent_t qb[$];
  logic [7:0] shadow [0:1023];

  int nvec  = 0;
  int nfail = 0;
  int nbrsp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (a_rsp_valid === 1'b1) begin
        chk("a_rsp_spurious", 32'(a_rsp_valid), 32'(qa.size() != 0));
        if (qa.size() != 0) begin
          ent_t e;
          e = qa.pop_front();
          chk("a_rsp_data", 32'(a_rsp_data), 32'(e.d));
          chk("a_rsp_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (b_rsp_valid === 1'b1) begin
        nbrsp++;
        chk("b_rsp_spurious", 32'(b_rsp_valid), 32'(qb.size() != 0));
        if (qb.size() != 0) begin
          ent_t e;
          e = qb.pop_front();
          chk("b_rsp_data", 32'(b_rsp_data), 32'(e.d));
          chk("b_rsp_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input logic av, input logic aw, input logic [9:0] aa, input logic [7:0] ad,
                      input logic bv, input logic bw, input logic [9:0] ba, input logic [7:0] bd,
                      input logic exp_ra, input logic exp_rb);
    a_req_valid = av; a_req_wr = aw; a_req_addr = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_wr = bw; b_req_addr = ba; b_req_wdata = bd;
    #1;
    chk("a_req_ready", 32'(a_req_ready), 32'(exp_ra));
    chk("b_req_ready", 32'(b_req_ready), 32'(exp_rb));
    if (av && a_req_ready === 1'b1) begin
      if (aw) shadow[aa] = ad;
      else qa.push_back('{d: shadow[aa], c: cyc + 2});
    end
    if (bv && b_req_ready === 1'b1) begin
      if (bw) shadow[ba] = bd;
      else qb.push_back('{d: shadow[ba], c: cyc + 2});
    end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 10'h0, 8'h0, 0, 0, 10'h0, 8'h0, 1, 1);
  endtask

  // Assert reset at a falling edge, check outputs immediately, release later.
  task automatic do_reset();
    resetn = 1'b0;
    a_req_valid = 1'b1;
    b_req_valid = 1'b1;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
    #1;
    chk("rst_a_ready", 32'(a_req_ready), 32'(0));
    chk("rst_b_ready", 32'(b_req_ready), 32'(0));
    chk("rst_ram_a", 32'({ram_we_a, ram_re_a, ram_addr_a, ram_data_a}), 32'(0));
    chk("rst_ram_b", 32'({ram_we_b, ram_re_b, ram_addr_b, ram_data_b}), 32'(0));
    chk("rst_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), 32'(0));
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'(0));
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int base;
    @(negedge clk);
    do_reset();

    // Write then immediately read back on channel A.
    step(1, 1, 10'h005, 8'hA5, 0, 0, 10'h0, 8'h0, 1, 1);
    chk("t1_we_a", 32'({ram_we_a, ram_re_a}), 32'(2'b10));
    chk("t1_addr_data_a", 32'({ram_addr_a, ram_data_a}), 32'({10'h005, 8'hA5}));
    step(1, 0, 10'h005, 8'h00, 0, 0, 10'h0, 8'h0, 1, 1);
    chk("t1_re_a", 32'({ram_we_a, ram_re_a}), 32'(2'b01));
    idle(1);
    chk("t1_re_a_drop", 32'({ram_we_a, ram_re_a}), 32'(0));
    idle(2);

    // Write/write hazard on the same address: A first, B one cycle later.
    do_reset();
    step(1, 1, 10'h010, 8'h11, 1, 1, 10'h010, 8'h22, 1, 0);
    chk("t2_cnt_after_hazard", 32'(conflict_cnt), 32'(1));
    step(0, 0, 10'h000, 8'h00, 1, 1, 10'h010, 8'h22, 1, 1);
    chk("t2_we_b", 32'({ram_we_b, ram_addr_b, ram_data_b}), 32'({1'b1, 10'h010, 8'h22}));
    chk("t2_cnt", 32'(conflict_cnt), 32'(1));
    step(1, 0, 10'h010, 8'h00, 0, 0, 10'h0, 8'h0, 1, 1);
    idle(3);

    // Sustained write/write hazard: strict alternation of grants.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 10'h3FF, 8'(8'h30 + i), 1, 1, 10'h3FF, 8'(8'h40 + i),
           (i % 2) == 0, (i % 2) == 1);
      chk("t3_we_a", 32'(ram_we_a), 32'((i % 2) == 0));
      chk("t3_we_b", 32'(ram_we_b), 32'((i % 2) == 1));
    end
    chk("t3_cnt", 32'(conflict_cnt), 32'(6));
    step(0, 0, 10'h0, 8'h0, 1, 0, 10'h3FF, 8'h00, 1, 1);
    idle(3);

    // Same-address read/read is not a hazard.
    do_reset();
    step(1, 1, 10'h020, 8'h5C, 0, 0, 10'h0, 8'h0, 1, 1);
    step(1, 0, 10'h020, 8'h00, 1, 0, 10'h020, 8'h00, 1, 1);
    idle(3);
    chk("t4_cnt", 32'(conflict_cnt), 32'(0));

    // Different addresses every cycle: never stalled.
    do_reset();
    step(0, 0, 10'h0, 8'h0, 1, 1, 10'h002, 8'h77, 1, 1);
    base = nbrsp;
    for (int i = 0; i < 8; i++)
      step(1, 1, 10'h001, 8'(i), 1, 0, 10'h002, 8'h00, 1, 1);
    idle(3);
    chk("t5_b_rsp_count", 32'(nbrsp - base), 32'(8));
    chk("t5_cnt", 32'(conflict_cnt), 32'(0));

    // Reset while a read is in flight.
    step(1, 1, 10'h0AB, 8'h3C, 0, 0, 10'h0, 8'h0, 1, 1);
    idle(1);
    step(1, 0, 10'h0AB, 8'h00, 0, 0, 10'h0, 8'h0, 1, 1);
    do_reset();
    @(negedge clk);
    step(1, 0, 10'h0AB, 8'h00, 0, 0, 10'h0, 8'h0, 1, 1);
    idle(4);

    chk("a_rsp_missing", 32'(qa.size()), 32'(0));
    chk("b_rsp_missing", 32'(qb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
